// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master.
// Holds the FSM state enum and the CPOL/CPHA mode decoders.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      HOLD
   } spi_state_t;

   function automatic logic cpol(input logic [1:0] mode);
      return mode[1];
   endfunction

   function automatic logic cpha(input logic [1:0] mode);
      return mode[0];
   endfunction

endpackage

// File: rtl/spi_master_clk_gen.sv
// SPI edge timer: counts DIVIDER clk cycles per sclk half-period.
// Ports: clk, rst_n, en (in XFER); lead_edge, trail_edge, last_edge strobes.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int DIVIDER    = 5,
   parameter int DATA_WIDTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic lead_edge,
   output logic trail_edge,
   output logic last_edge
);

   localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
   localparam int EW = $clog2(2 * DATA_WIDTH + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [EW-1:0] ecnt_q, ecnt_d;
   logic          tick;

   always_comb begin
      tick   = en && (cnt_q == CW'(DIVIDER - 1));
      cnt_d  = cnt_q;
      ecnt_d = ecnt_q;
      if (!en) begin
         cnt_d  = '0;
         ecnt_d = '0;
      end else if (tick) begin
         cnt_d  = '0;
         ecnt_d = ecnt_q + 1'b1;
      end else begin
         cnt_d  = cnt_q + 1'b1;
      end
      // ecnt_q holds edges already taken, so an even count means
      // the next edge is odd-numbered (leading).
      lead_edge  = tick && !ecnt_q[0];
      trail_edge = tick && ecnt_q[0];
      last_edge  = tick && (ecnt_q == EW'(2 * DATA_WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         ecnt_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         ecnt_q <= ecnt_d;
      end
   end

endmodule

// File: rtl/spi_master.sv
// SPI bus master: one select at a time, mode/divider/width by parameter.
// Ports: clk, rst_n, start, tx_data, slave_id, miso in; sclk, mosi, SS_n, ready, rx_data out.
module spi_master
   import spi_pkg::*;
#(
   parameter int         SYS_CLK_FREQ = 50_000_000,
   parameter int         SPI_CLK_FREQ = 5_000_000,
   parameter logic [1:0] SPI_MODE     = 2'd0,
   parameter int         NUM_CS       = 1,
   parameter int         DATA_WIDTH   = 8,
   localparam int        SW           = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic [SW-1:0]         slave_id,
   input  logic                  miso,
   output logic                  sclk,
   output logic                  mosi,
   output logic [NUM_CS-1:0]     SS_n,
   output logic                  ready,
   output logic [DATA_WIDTH-1:0] rx_data
);

   localparam int DIVIDER = SYS_CLK_FREQ / (2 * SPI_CLK_FREQ);
   localparam int CW      = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
   localparam logic CPOL  = cpol(SPI_MODE);
   localparam logic CPHA  = cpha(SPI_MODE);
   localparam logic [SW:0] NCS = (SW + 1)'(NUM_CS);

   if (DIVIDER < 1) begin : g_div_chk
      $error("spi_master: DIVIDER must be at least 1");
   end

   spi_state_t              state_q, state_d;
   logic [DATA_WIDTH-1:0]   tx_sh_q, tx_sh_d;
   logic [DATA_WIDTH-1:0]   rx_sh_q, rx_sh_d;
   logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
   logic [NUM_CS-1:0]       ss_n_q, ss_n_d;
   logic [CW-1:0]           hold_q, hold_d;
   logic                    sclk_q, sclk_d;
   logic                    mosi_q, mosi_d;
   logic                    ready_q, ready_d;
   logic                    lead_edge, trail_edge, last_edge;
   logic                    sample_edge, id_ok;

   spi_clk_gen #(
      .DIVIDER   (DIVIDER),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_clk_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (state_q == XFER),
      .lead_edge (lead_edge),
      .trail_edge(trail_edge),
      .last_edge (last_edge)
   );

   assign id_ok       = ({1'b0, slave_id} < NCS);
   assign sample_edge = CPHA ? trail_edge : lead_edge;

   always_comb begin
      state_d   = state_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      ss_n_d    = ss_n_q;
      hold_d    = hold_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      unique case (state_q)
         IDLE: begin
            sclk_d = CPOL;
            mosi_d = 1'b0;
            ss_n_d = '1;
            if (start && id_ok) begin
               state_d = XFER;
               tx_sh_d = tx_data;
               ss_n_d  = ~(NUM_CS'(1) << slave_id);
               if (!CPHA) mosi_d = tx_data[DATA_WIDTH-1];
            end
         end
         XFER: begin
            if (lead_edge || trail_edge) sclk_d = ~sclk_q;
            if (sample_edge)
               rx_sh_d = (rx_sh_q << 1) | DATA_WIDTH'(miso);
            // CPHA=0 preloads the MSB, so it advances on trailing
            // edges; CPHA=1 presents each bit on its leading edge.
            if (!CPHA && trail_edge && !last_edge) begin
               tx_sh_d = tx_sh_q << 1;
               mosi_d  = tx_sh_d[DATA_WIDTH-1];
            end
            if (CPHA && lead_edge) begin
               mosi_d  = tx_sh_q[DATA_WIDTH-1];
               tx_sh_d = tx_sh_q << 1;
            end
            if (last_edge) begin
               rx_data_d = rx_sh_d;
               state_d   = HOLD;
               hold_d    = '0;
            end
         end
         HOLD: begin
            if (hold_q == CW'(DIVIDER - 1)) begin
               state_d = IDLE;
               ss_n_d  = '1;
               mosi_d  = 1'b0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_data_q <= '0;
         ss_n_q    <= '1;
         hold_q    <= '0;
         sclk_q    <= CPOL;
         mosi_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         rx_data_q <= rx_data_d;
         ss_n_q    <= ss_n_d;
         hold_q    <= hold_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         ready_q   <= ready_d;
      end
   end

   assign sclk    = sclk_q;
   assign mosi    = mosi_q;
   assign SS_n    = ss_n_q;
   assign ready   = ready_q;
   assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master: one instance per SPI mode, each with a slave model.
// Expected words are queued at issue and compared when the transfer completes.
module tb_spi_master;

   localparam int NCS = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       start_s [4];
   logic [7:0] tx_s    [4];
   logic [1:0] sid_s   [4];
   logic [7:0] slv_tx  [4];
   wire        sclk_s  [4];
   wire        mosi_s  [4];
   wire  [2:0] ssn_s   [4];
   wire        ready_s [4];
   wire  [7:0] rx_s    [4];
   wire  [7:0] cap_s   [4];

   typedef struct {
      int         m;
      logic [7:0] rx;
      logic [7:0] mo;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   for (genvar m = 0; m < 4; m++) begin : g
      localparam logic CPOL_M = 1'((m >> 1) & 1);
      localparam logic CPHA_M = 1'(m & 1);
      logic       miso = 1'b0;
      logic [7:0] sh   = 8'h00;
      logic [7:0] cap  = 8'h00;

      spi_master #(
         .SPI_MODE  (2'(m)),
         .NUM_CS    (NCS),
         .DATA_WIDTH(8)
      ) u_dut (
         .clk     (clk),
         .rst_n   (rst_n),
         .start   (start_s[m]),
         .tx_data (tx_s[m]),
         .slave_id(sid_s[m]),
         .miso    (miso),
         .sclk    (sclk_s[m]),
         .mosi    (mosi_s[m]),
         .SS_n    (ssn_s[m]),
         .ready   (ready_s[m]),
         .rx_data (rx_s[m])
      );

      always @(ssn_s[m]) begin
         if (ssn_s[m] != 3'b111) begin
            sh = slv_tx[m];
            if (!CPHA_M) begin
               miso = sh[7];
               sh   = sh << 1;
            end
         end
      end

      always @(sclk_s[m]) begin
         if (ssn_s[m] != 3'b111) begin
            if ((sclk_s[m] != CPOL_M) != CPHA_M) begin
               cap = {cap[6:0], mosi_s[m]};
            end else begin
               miso = sh[7];
               sh   = sh << 1;
            end
         end
      end

      assign cap_s[m] = cap;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(int m, logic [7:0] tx, logic [7:0] mi,
                        logic [1:0] sid);
      logic [2:0] sel;
      sel        = ~(3'b001 << sid);
      slv_tx[m]  = mi;
      tx_s[m]    = tx;
      sid_s[m]   = sid;
      start_s[m] = 1'b1;
      sb.push_back('{m, mi, tx});
      tick();
      start_s[m] = 1'b0;
      chk("ss_select", 32'(ssn_s[m]), 32'(sel));
      chk("ready_low", 32'(ready_s[m]), 32'd0);
   endtask

   task automatic wait_done(int m, int poke, output int n_e1,
                            output int n_e2, output int n_rx);
      logic [7:0] rx0;
      logic [2:0] ss0;
      logic       pol;
      int         n_rdy;
      exp_t       e;
      rx0   = rx_s[m];
      ss0   = ssn_s[m];
      pol   = 1'((m >> 1) & 1);
      n_e1  = -1;
      n_e2  = -1;
      n_rx  = -1;
      n_rdy = -1;
      for (int n = 1; n <= 200; n++) begin
         tick();
         if (n_e1 < 0 && sclk_s[m] != pol) n_e1 = n;
         if (n_e1 > 0 && n_e2 < 0 && sclk_s[m] == pol) n_e2 = n;
         if (n_rx < 0 && rx_s[m] != rx0) n_rx = n;
         if (poke > 0 && n == poke) begin
            tx_s[m]    = ~tx_s[m];
            sid_s[m]   = 2'd2;
            start_s[m] = 1'b1;
         end
         if (poke > 0 && n == poke + 1) begin
            start_s[m] = 1'b0;
            chk("busy_start_ignored", 32'(ssn_s[m]), 32'(ss0));
         end
         if (ready_s[m]) begin
            n_rdy = n;
            break;
         end
      end
      chk("ready_latency", 32'(n_rdy), 32'd85);
      chk("ss_released", 32'(ssn_s[m]), 32'h7);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("rx_data", 32'(rx_s[e.m]), 32'(e.rx));
         chk("mosi_word", 32'(cap_s[e.m]), 32'(e.mo));
      end else begin
         chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      end
   endtask

   initial begin
      int         e1, e2, erx;
      logic [7:0] tx, mi;

      rst_n = 1'b0;
      for (int m = 0; m < 4; m++) begin
         start_s[m] = 1'b0;
         tx_s[m]    = 8'h00;
         sid_s[m]   = 2'd0;
         slv_tx[m]  = 8'h00;
      end
      tick();
      tick();
      for (int m = 0; m < 4; m++) begin
         chk("rst_ready", 32'(ready_s[m]), 32'd1);
         chk("rst_ss", 32'(ssn_s[m]), 32'h7);
         chk("rst_sclk", 32'(sclk_s[m]), 32'((m >> 1) & 1));
         chk("rst_mosi", 32'(mosi_s[m]), 32'd0);
         chk("rst_rx", 32'(rx_s[m]), 32'd0);
      end
      rst_n = 1'b1;
      tick();

      // Out-of-range slave index must be dropped.
      start_s[0] = 1'b1;
      sid_s[0]   = 2'd3;
      tx_s[0]    = 8'h77;
      tick();
      start_s[0] = 1'b0;
      chk("bad_id_ready", 32'(ready_s[0]), 32'd1);
      chk("bad_id_ss", 32'(ssn_s[0]), 32'h7);
      tick();
      chk("bad_id_idle", 32'(ready_s[0]), 32'd1);

      // Mode 0 with cycle-exact timing.
      issue(0, 8'h11, 8'h11, 2'd0);
      chk("m0_mosi_msb", 32'(mosi_s[0]), 32'd0);
      wait_done(0, 0, e1, e2, erx);
      chk("m0_edge1", 32'(e1), 32'd5);
      chk("m0_rx_time", 32'(erx), 32'd80);
      chk("m0_idle_mosi", 32'(mosi_s[0]), 32'd0);

      issue(0, 8'hA5, 8'h3C, 2'd1);
      chk("m0_mosi_msb2", 32'(mosi_s[0]), 32'd1);
      wait_done(0, 0, e1, e2, erx);
      chk("m0_edge1b", 32'(e1), 32'd5);
      chk("m0_edge2", 32'(e2), 32'd10);
      chk("m0_rx_time2", 32'(erx), 32'd80);

      // Remaining modes.
      for (int m = 1; m < 4; m++) begin
         chk("idle_sclk", 32'(sclk_s[m]), 32'((m >> 1) & 1));
         issue(m, 8'hC3, 8'h5A, 2'd2);
         wait_done(m, 0, e1, e2, erx);
         chk("mode_edge1", 32'(e1), 32'd5);
         chk("mode_edge2", 32'(e2), 32'd10);
         chk("mode_rx_time", 32'(erx), 32'd80);
         chk("end_sclk", 32'(sclk_s[m]), 32'((m >> 1) & 1));
      end

      // Abort mid-transfer after four bits.
      issue(0, 8'hFF, 8'h00, 2'd0);
      repeat (40) tick();
      rst_n = 1'b0;
      tick();
      chk("abort_ss", 32'(ssn_s[0]), 32'h7);
      chk("abort_ready", 32'(ready_s[0]), 32'd1);
      chk("abort_rx", 32'(rx_s[0]), 32'd0);
      chk("abort_sclk", 32'(sclk_s[0]), 32'd0);
      chk("abort_mosi", 32'(mosi_s[0]), 32'd0);
      rst_n = 1'b1;
      sb.delete(sb.size() - 1);
      tick();
      issue(0, 8'h11, 8'h11, 2'd0);
      wait_done(0, 0, e1, e2, erx);
      chk("post_abort_rx_time", 32'(erx), 32'd80);

      // Back-to-back, each start in the first ready cycle.
      for (int i = 0; i < 5; i++) begin
         tx = 8'($urandom);
         mi = 8'($urandom);
         issue(0, tx, mi, 2'(i % NCS));
         wait_done(0, (i == 0) ? 20 : 0, e1, e2, erx);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
